// File: rtl/dw_window_pkg.sv
// dw_window_gen shared definitions.
// Default geometry, tap indices and window bit-offset helper.
package dw_window_pkg;

  localparam int DEF_CH = 8;
  localparam int DEF_AW = 8;
  localparam int KTAPS  = 9;

  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  function automatic int tap_off(input int aw, input int c, input int t);
    return aw * (KTAPS * c + t);
  endfunction

endpackage

// File: rtl/dw_line_buffer.sv
// One image row of pixels.
// Combinational read, synchronous write.
module dw_line_buffer #(
  parameter int DEPTH = 8,
  parameter int DW    = 64,
  parameter int AD    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AD-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/dw_window_gen.sv
// Streaming 3x3 zero-padded window generator.
// Feeds packed 9-tap windows to depthwise conv layers.
module dw_window_gen
  import dw_window_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int AW    = DEF_AW,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  input  logic [CH*AW-1:0]      in_act,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [KTAPS*CH*AW-1:0] window_act,
  output logic                  out_last
);

  localparam int PW = CH * AW;
  localparam int WW = KTAPS * PW;
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int LA = $clog2(IMG_W);

  typedef logic [2:0][PW-1:0] col_t;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_pad;
  logic          y_pad;
  logic          pad;
  logic          step;
  logic          emit;
  logic          last_pos;
  logic          mask_t;
  logic          mask_l;
  logic          we;
  logic [PW-1:0] pix;
  logic [PW-1:0] rd0;
  logic [PW-1:0] rd1;
  col_t          col_l;
  col_t          col_m;
  col_t          newc;
  logic [WW-1:0] win;

  assign x_pad    = (x == XW'(IMG_W));
  assign y_pad    = (y == YW'(IMG_H));
  assign pad      = x_pad || y_pad;
  assign in_ready = !pad;
  assign step     = pad || in_valid;
  assign emit     = (y != '0) && (x != '0);
  assign last_pos = x_pad && y_pad;
  assign mask_t   = (y == YW'(1));
  assign mask_l   = (x == XW'(1));
  assign pix      = pad ? '0 : in_act;
  assign we       = step && !x_pad;

  dw_line_buffer #(.DEPTH(IMG_W), .DW(PW), .AD(LA)) u_lb0 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .addr  (x[LA-1:0]),
    .wdata (pix),
    .rdata (rd0)
  );

  dw_line_buffer #(.DEPTH(IMG_W), .DW(PW), .AD(LA)) u_lb1 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .addr  (x[LA-1:0]),
    .wdata (rd0),
    .rdata (rd1)
  );

  // row 0 = oldest line (y-2), row 2 = incoming pixel (y)
  always_comb begin
    newc = '0;
    if (!x_pad) begin
      newc[0] = rd1;
      newc[1] = rd0;
      newc[2] = pix;
    end
  end

  always_comb begin
    win = '0;
    for (int c = 0; c < CH; c++) begin
      for (int ky = 0; ky < 3; ky++) begin
        win[tap_off(AW, c, TAP_TL + 3*ky) +: AW] =
          (mask_l || (ky == 0 && mask_t)) ? {AW{1'b0}}
                                          : col_l[ky][AW*c +: AW];
        win[tap_off(AW, c, TAP_TL + 3*ky + 1) +: AW] =
          (ky == 0 && mask_t) ? {AW{1'b0}} : col_m[ky][AW*c +: AW];
        win[tap_off(AW, c, TAP_TL + 3*ky + 2) +: AW] =
          (ky == 0 && mask_t) ? {AW{1'b0}} : newc[ky][AW*c +: AW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x          <= '0;
      y          <= '0;
      col_l      <= '0;
      col_m      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      window_act <= '0;
    end else begin
      out_valid <= step && emit;
      out_last  <= step && emit && last_pos;
      if (step) begin
        if (emit) window_act <= win;
        col_l <= col_m;
        col_m <= newc;
        if (x_pad) begin
          x <= '0;
          y <= y_pad ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dw_window_gen.sv
// Scoreboard bench for dw_window_gen.
// Windows come from an image-array model with zero padding.
module tb_dw_window_gen;

  localparam int CH = 8;
  localparam int AW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = CH * AW;
  localparam int WW = 9 * PW;

  typedef struct {
    logic [WW-1:0] w;
    logic          l;
  } exp_t;

  logic          clk = 0;
  logic          rstn = 0;
  logic          in_valid = 0;
  logic [PW-1:0] in_act = '0;
  logic          in_ready;
  logic          out_valid;
  logic [WW-1:0] window_act;
  logic          out_last;

  int errors = 0;
  int checks = 0;
  int cyc = 0, low = 0, steps = 0;
  int snap_cyc = 0, snap_low = 0, snap_steps = 0;
  int last_cnt = 0;

  exp_t          sb  [$];
  logic [WW-1:0] got [$];
  logic [PW-1:0] img [H][W];

  int l_corner [9] = '{0, 0, 0, 0, 1, 2, 0, 17, 18};
  int l_centre [9] = '{1, 2, 3, 17, 18, 19, 33, 34, 35};
  int l_end    [9] = '{35, 36, 0, 51, 52, 0, 0, 0, 0};

  dw_window_gen #(.CH(CH), .AW(AW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_act     (in_act),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .window_act (window_act),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [WW-1:0] act,
                      input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] model_win(input int r, input int c);
    logic [WW-1:0] v;
    int yy, xx;
    v = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int ky = 0; ky < 3; ky++)
        for (int kx = 0; kx < 3; kx++) begin
          yy = r - 1 + ky;
          xx = c - 1 + kx;
          if (yy >= 0 && yy < H && xx >= 0 && xx < W)
            v[AW*(9*ch + 3*ky + kx) +: AW] = img[yy][xx][AW*ch +: AW];
        end
    return v;
  endfunction

  function automatic logic [WW-1:0] const_win(input int lst[9]);
    logic [WW-1:0] v;
    v = '0;
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++)
        v[AW*(9*ch + t) +: AW] = AW'(lst[t]);
    return v;
  endfunction

  task automatic fill_golden();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = {CH{AW'(16*r + c + 1)}};
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = {$urandom, $urandom};
  endtask

  task automatic push_exp(input int r, input int c);
    exp_t e;
    e.w = model_win(r, c);
    e.l = (r == H-1) && (c == W-1);
    sb.push_back(e);
  endtask

  task automatic send(input logic [PW-1:0] d, input int gapmax);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    if (g > 0) begin
      in_valid = 0;
      repeat (g) @(posedge clk);
      #1;
    end
    in_valid = 1;
    in_act   = d;
    for (g = 0; g < 100; g++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (g == 100) chk("in_ready_timeout", 64'(g), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string nm, input int gapmax);
    int lastn, g;
    cyc = 0; low = 0; steps = 0;
    got.delete();
    lastn = last_cnt;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) push_exp(r, c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) send(img[r][c], gapmax);
    in_valid = 0;
    for (g = 0; g < 200; g++) begin
      @(posedge clk);
      if (last_cnt != lastn) break;
    end
    #1;
    if (g == 200) chk({nm, "_last_timeout"}, 64'(g), 0);
    chk({nm, "_windows"}, 64'(got.size()), 16);
    chk({nm, "_sb_empty"}, 64'(sb.size()), 0);
    chk({nm, "_ready_low"}, 64'(snap_low), 9);
    chk({nm, "_steps"}, 64'(snap_steps), 25);
    if (gapmax == 0) chk({nm, "_cycles"}, 64'(snap_cyc), 25);
  endtask

  task automatic const_checks(input string nm, input int full);
    if (got.size() >= 1)
      chkw({nm, "_corner"}, got[0], const_win(l_corner));
    if (full != 0 && got.size() == 16) begin
      chkw({nm, "_centre11"}, got[5], const_win(l_centre));
      chkw({nm, "_end33"}, got[15], const_win(l_end));
    end
  endtask

  task automatic reset_checks(input string nm);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({nm, "_out_valid"}, 64'(out_valid), 0);
      chk({nm, "_out_last"}, 64'(out_last), 0);
      chkw({nm, "_window"}, window_act, '0);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (out_valid) begin
        got.push_back(window_act);
        if (sb.size() == 0) begin
          chk("unexpected_window", 64'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chkw("window", window_act, e.w);
          chk("out_last", 64'(out_last), 64'(e.l));
        end
        if (out_last) begin
          snap_cyc   = cyc;
          snap_low   = low;
          snap_steps = steps;
          last_cnt++;
        end
      end
      cyc++;
      if (!in_ready) low++;
      if (!in_ready || in_valid) steps++;
    end
  end

  initial begin
    reset_checks("reset");
    @(posedge clk);
    #1;
    rstn = 1;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 1);
    @(posedge clk);
    #1;

    fill_golden();
    run_frame("golden", 0);
    const_checks("golden", 1);

    fill_random();
    run_frame("stall", 3);

    fill_golden();
    run_frame("b2b", 0);
    const_checks("b2b", 1);

    got.delete();
    push_exp(0, 0);
    push_exp(0, 1);
    for (int i = 0; i < 7; i++) send(img[i / W][i % W], 0);
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("partial_windows", 64'(got.size()), 2);
    chk("partial_sb_empty", 64'(sb.size()), 0);
    const_checks("partial", 0);
    rstn = 0;
    reset_checks("midreset");
    @(posedge clk);
    #1;
    rstn = 1;
    @(negedge clk);
    chk("midreset_in_ready", 64'(in_ready), 1);
    @(posedge clk);
    #1;
    run_frame("restart", 0);
    const_checks("restart", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
